// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Read-mode encodings, default geometry and a constant-foldable clog2.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
// Contents after power-up are undefined; the controller never reads an unwritten slot.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/syn_fifo_v2.sv
// Synchronous FIFO with registered status flags, sticky error flags and a
// choice of registered-read or first-word-fall-through output.
module syn_fifo_v2
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = MODE_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    fifo_almost_full,
  output logic                    fifo_almost_empty,
  output logic [clog2(DEPTH):0]   data_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("syn_fifo_v2: DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("syn_fifo_v2: AE_LEVEL must be below AF_LEVEL");
  end

  // Handshake: a write is taken when wr_en is high and the FIFO is not full
  // (or a read is taken in the same cycle); a read is taken when rd_en is high
  // and the FIFO is not empty. rd_valid marks the cycle(s) rd_data is meaningful.
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_fire, rd_fire;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    rd_fire  = rd_en && !empty_q;
    wr_fire  = wr_en && (!full_q || rd_fire);
    wr_ptr_d = wr_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == FULL_L);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_L);
    ae_d    = (count_d <= AE_L);

    // A new error in the same cycle as err_clr wins, so the set comes last.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    if (wr_en && !wr_fire) ovf_d = 1'b1;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (rd_en && empty_q) unf_d = 1'b1;

    rd_data_d  = rd_fire ? mem_rdata : rd_data_q;
    rd_valid_d = rd_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // In fall-through mode the head entry is shown directly; zero while empty.
  assign rd_data  = (FWFT == MODE_FWFT) ? (empty_q ? '0 : mem_rdata) : rd_data_q;
  assign rd_valid = (FWFT == MODE_FWFT) ? !empty_q : rd_valid_q;

  assign fifo_full         = full_q;
  assign fifo_empty        = empty_q;
  assign fifo_almost_full  = af_q;
  assign fifo_almost_empty = ae_q;
  assign data_count        = count_q;
  assign overflow          = ovf_q;
  assign underflow         = unf_q;

endmodule

// File: tb/tb_syn_fifo_v2.sv
// Directed bench for syn_fifo_v2: a registered-read instance checked through an
// expected-data queue and monitor, plus a fall-through instance checked directly.
module tb_syn_fifo_v2;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         wr_en0, rd_en0, err_clr0;
  logic [W-1:0] wr_data0;
  logic [W-1:0] rd_data0;
  logic         rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [3:0]   count0;
  logic         wr_en1, rd_en1, err_clr1;
  logic [W-1:0] wr_data1;
  logic [W-1:0] rd_data1;
  logic         rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0]   count1;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  syn_fifo_v2 #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .err_clr(err_clr0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .fifo_full(full0), .fifo_empty(empty0), .fifo_almost_full(af0),
    .fifo_almost_empty(ae0), .data_count(count0), .overflow(ovf0), .underflow(unf0)
  );

  syn_fifo_v2 #(.WIDTH(8), .DEPTH(8), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .err_clr(err_clr1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .fifo_full(full1), .fifo_empty(empty1), .fifo_almost_full(af1),
    .fifo_almost_empty(ae1), .data_count(count1), .overflow(ovf1), .underflow(unf1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks for the registered-read instance
  task automatic write0(input logic [W-1:0] d);
    wr_en0 = 1'b1; wr_data0 = d;
    step();
    wr_en0 = 1'b0;
  endtask

  task automatic read0(input logic [W-1:0] e);
    rd_en0 = 1'b1; exp_q.push_back(e);
    step();
    rd_en0 = 1'b0;
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the queue head
  always @(negedge clk) begin
    if (!rst && rd_valid0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no valid", rd_data0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data0 !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data0, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    wr_en0 = 0; rd_en0 = 0; err_clr0 = 0; wr_data0 = '0;
    wr_en1 = 0; rd_en1 = 0; err_clr1 = 0; wr_data1 = '0;
    step(); step();
    rst = 1'b0;

    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_ae", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_af", af0, 0);
    chk("rst_valid", rd_valid0, 0);
    chk("rst_data", rd_data0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);

    // Fill 1..8 with almost-full from 6, then drain in order
    for (int i = 1; i <= 8; i++) begin
      write0(W'(i));
      chk("fill_count", count0, i);
      chk("fill_af", af0, (i >= 6));
      chk("fill_full", full0, (i == 8));
      chk("fill_ae", ae0, (i <= 2));
    end
    for (int i = 1; i <= 8; i++) read0(W'(i));
    step();
    chk("drain_empty", empty0, 1);
    chk("drain_count", count0, 0);

    // Overflow while full, clear, then simultaneous access while full
    for (int i = 0; i < 8; i++) write0(W'(8'h10 + i));
    write0(8'hEE);
    chk("ovf_set", ovf0, 1);
    chk("ovf_count", count0, 8);
    err_clr0 = 1'b1; step(); err_clr0 = 1'b0;
    chk("ovf_clr", ovf0, 0);
    wr_en0 = 1'b1; wr_data0 = 8'h18; rd_en0 = 1'b1; exp_q.push_back(8'h10);
    step();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    chk("full_rw_count", count0, 8);
    chk("full_rw_full", full0, 1);
    chk("full_rw_ovf", ovf0, 0);
    for (int i = 1; i <= 8; i++) read0(W'(8'h10 + i));
    step();
    chk("drain2_empty", empty0, 1);

    // Simultaneous read and write on an empty FIFO
    wr_en0 = 1'b1; wr_data0 = 8'h5A; rd_en0 = 1'b1;
    step();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    chk("unf_set", unf0, 1);
    chk("unf_count", count0, 1);
    read0(8'h5A);
    step();
    chk("unf_sticky", unf0, 1);
    rd_en0 = 1'b1; err_clr0 = 1'b1; step();
    chk("unf_clr_collide", unf0, 1);
    rd_en0 = 1'b0; step(); err_clr0 = 1'b0;
    chk("unf_clr", unf0, 0);

    // Steady state at count 4 across pointer wraps
    for (int i = 0; i < 4; i++) write0(W'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      wr_en0 = 1'b1; wr_data0 = W'(8'h24 + i);
      rd_en0 = 1'b1; exp_q.push_back(W'(8'h20 + i));
      step();
      chk("stream_count", count0, 4);
    end
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    for (int i = 0; i < 4; i++) read0(W'(8'h34 + i));
    step();
    chk("stream_empty", empty0, 1);

    // Reset mid-operation with flags set and a write pending
    rd_en0 = 1'b1; step(); rd_en0 = 1'b0;
    chk("pre_rst_unf", unf0, 1);
    for (int i = 0; i < 5; i++) write0(W'(8'h60 + i));
    chk("pre_rst_count", count0, 5);
    rst = 1'b1; wr_en0 = 1'b1; wr_data0 = 8'h99;
    step();
    rst = 1'b0; wr_en0 = 1'b0;
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_unf", unf0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_valid", rd_valid0, 0);
    write0(8'h77);
    chk("post_rst_count", count0, 1);
    read0(8'h77);
    step();

    // Fall-through instance
    chk("fwft_rst_empty", empty1, 1);
    chk("fwft_rst_valid", rd_valid1, 0);
    wr_en1 = 1'b1; wr_data1 = 8'h33; step();
    wr_data1 = 8'h44; step();
    wr_en1 = 1'b0;
    chk("fwft_valid", rd_valid1, 1);
    chk("fwft_data0", rd_data1, 8'h33);
    chk("fwft_count", count1, 2);
    rd_en1 = 1'b1; step();
    chk("fwft_data1", rd_data1, 8'h44);
    chk("fwft_valid1", rd_valid1, 1);
    step();
    rd_en1 = 1'b0;
    chk("fwft_empty", empty1, 1);
    chk("fwft_valid_low", rd_valid1, 0);

    step(); step();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syn_fifo_v2.md
SYN_FIFO_V2 -- requirements
Module: syn_fifo_v2

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, fill level at or above which almost-full asserts.
REQ-004 Parameter AE_LEVEL, default 2, fill level at or below which almost-empty asserts.
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request (FWFT=1: acknowledge of presented word).
REQ-011 err_clr  input  1  clears sticky error flags.
REQ-012 rd_data  output  WIDTH  read data.
REQ-013 rd_valid  output  1  rd_data holds a valid word this cycle.
REQ-014 fifo_full / fifo_empty  output  1 each  fill == DEPTH / fill == 0.
REQ-015 fifo_almost_full / fifo_almost_empty  output  1 each  fill >= AF_LEVEL / fill <= AE_LEVEL.
REQ-016 data_count  output  clog2(DEPTH)+1  current fill level.
REQ-017 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 Write accepted when wr_en && (!fifo_full || read accepted same cycle); word stored at wr_ptr, wr_ptr increments.
REQ-019 Read accepted when rd_en && !fifo_empty; rd_ptr increments.
REQ-020 Pointers clog2(DEPTH) bits, wrap DEPTH-1 -> 0 without extra logic.
REQ-021 data_count: +1 write only, -1 read only, unchanged on both or neither; never exceeds DEPTH nor drops below 0.
REQ-022 All status flags registered, derived from next count, valid same cycle as data_count.
REQ-023 Full with wr_en && rd_en: both accepted, count stays DEPTH, fifo_full stays 1.
REQ-024 Empty with wr_en && rd_en: write only accepted, read rejected, underflow set, count becomes 1.
REQ-025 overflow set on wr_en while full and write not accepted; underflow set on rd_en while empty; both hold until err_clr or rst.
REQ-026 err_clr and new error same cycle: flag remains set.
REQ-027 Rejected accesses change no pointer, count or memory.
REQ-028 FWFT=0: rd_data registered, updated 1 cycle after accepted read; rd_valid pulses 1 cycle with it; otherwise rd_data holds last value.
REQ-029 FWFT=1: rd_data = entry at rd_ptr while !fifo_empty, rd_valid = !fifo_empty; first write visible the cycle after it is accepted; accepted read shows next entry the following cycle.

Reset
REQ-030 rst high at clk edge: pointers, data_count, rd_data, rd_valid, overflow, underflow, fifo_full, fifo_almost_full -> 0; fifo_empty, fifo_almost_empty -> 1.
REQ-031 rst dominates wr_en, rd_en, err_clr same cycle; storage array not reset.
REQ-032 rst mid-operation discards contents; first post-reset write behaves as into empty FIFO.

Structure
REQ-033 Shared package fifo_pkg holds clog2 function, read-mode constants (MODE_STD=0, MODE_FWFT=1) and default WIDTH/DEPTH.
REQ-034 Storage in sub-module fifo_mem: DEPTH x WIDTH, synchronous write, asynchronous read, no reset.
REQ-035 Elaboration-time check rejects non-power-of-two DEPTH or AE_LEVEL >= AF_LEVEL.

Verification
REQ-036 WIDTH=8, DEPTH=8, FWFT=0: write 8 words 0x01..0x08 -> fifo_full=1, count=8, almost_full from count 6; read 8 -> rd_data 0x01..0x08 in order, each 1 cycle after rd_en, fifo_empty=1.
REQ-037 Full, wr_en=1 one cycle, rd_en=0 -> overflow=1, count=8, contents unchanged; err_clr pulse -> overflow=0.
REQ-038 Empty, rd_en=1 and wr_en=1 with 0x5A -> underflow=1, count=1; next read returns 0x5A.
REQ-039 Fill 20 words in continuous simultaneous read/write at count 4 -> count stays 4, order preserved across two pointer wraps.
REQ-040 FWFT=1: write 0x33 -> next cycle rd_valid=1, rd_data=0x33 without rd_en; rd_en -> fifo_empty=1 next cycle.
REQ-041 Count 5, rst asserted 1 cycle with wr_en=1 -> count=0, fifo_empty=1, all error flags 0, write ignored.
